// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b, LSB first: one full-subtract cell (two half subtractors plus a
// registered borrow) sequenced by a three-state FSM with start/busy/done handshake.

module serial_subtractor_hs (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic b_o
);
    assign d_o = x_i ^ y_i;
    assign b_o = ~x_i & y_i;
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d, res_shift;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             d1, b1, d, b2, br_next;

    // Full subtract = HS(a0,b0) followed by HS(partial diff, borrow in).
    serial_subtractor_hs u_hs0 (.x_i(a_q[0]), .y_i(b_q[0]), .d_o(d1), .b_o(b1));
    serial_subtractor_hs u_hs1 (.x_i(d1),     .y_i(br_q),   .d_o(d),  .b_o(b2));
    assign br_next = b1 | b2;

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = d;
        end else begin : g_res_wn
            assign res_shift = {d, res_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + CW'(1);
                // Publish only on the last bit so the previous result stays visible.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy       = (state_q == S_SHIFT);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and random checks of serial_subtractor_ctrl at WIDTH = 8, 1 and 13.

module tb_serial_subtractor_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s8, s1, s13;
    logic [7:0]  a8, b8;
    logic [0:0]  a1, b1;
    logic [12:0] a13, b13;
    logic        busy8, done8, bo8, busy1, done1, bo1, busy13, done13, bo13;
    logic [7:0]  diff8;
    logic [0:0]  diff1;
    logic [12:0] diff13;

    int n_chk  = 0;
    int n_pass = 0;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8));
    serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1));
    serial_subtractor_ctrl #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst(rst), .start(s13), .a(a13), .b(b13),
        .busy(busy13), .done(done13), .diff(diff13), .borrow_out(bo13));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_in(input int sel, input logic st, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            1:       begin s1  = st; a1  = a[0:0];  b1  = b[0:0];  end
            13:      begin s13 = st; a13 = a[12:0]; b13 = b[12:0]; end
            default: begin s8  = st; a8  = a[7:0];  b8  = b[7:0];  end
        endcase
    endtask

    function automatic logic o_busy(input int sel);
        return (sel == 1) ? busy1 : (sel == 13) ? busy13 : busy8;
    endfunction
    function automatic logic o_done(input int sel);
        return (sel == 1) ? done1 : (sel == 13) ? done13 : done8;
    endfunction
    function automatic logic o_bo(input int sel);
        return (sel == 1) ? bo1 : (sel == 13) ? bo13 : bo8;
    endfunction
    function automatic logic [31:0] o_diff(input int sel);
        return (sel == 1) ? 32'(diff1) : (sel == 13) ? 32'(diff13) : 32'(diff8);
    endfunction

    // Entered on a negedge; returns on the negedge of the DONE cycle.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ed, input logic eb, input string tag);
        int nb = 0;
        int early = 0;
        set_in(sel, 1'b1, a, b);
        for (int i = 0; i < sel; i++) begin
            @(negedge clk);
            set_in(sel, 1'b0, ~a, ~b);
            if (o_busy(sel)) nb++;
            if (o_done(sel)) early++;
        end
        @(negedge clk);
        chk({tag, "/busy_cycles"}, nb, sel);
        chk({tag, "/early_done"}, early, 0);
        chk({tag, "/done"}, o_done(sel), 1'b1);
        chk({tag, "/diff"}, o_diff(sel), ed);
        chk({tag, "/borrow"}, o_bo(sel), eb);
    endtask

    initial begin
        int dcnt, low;
        logic [31:0] ra, rb, m;
        rst = 1'b1;
        s8 = 0; s1 = 0; s13 = 0;
        a8 = 0; b8 = 0; a1 = 0; b1 = 0; a13 = 0; b13 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset/busy", busy8, 1'b0);
        chk("reset/done", done8, 1'b0);
        chk("reset/diff", diff8, 8'h00);
        chk("reset/borrow", bo8, 1'b0);
        @(negedge clk);

        run_op(8, 32'h05, 32'h03, 32'h02, 1'b0, "05-03");
        run_op(8, 32'h03, 32'h05, 32'hFE, 1'b1, "03-05");
        run_op(8, 32'h00, 32'h00, 32'h00, 1'b0, "00-00");
        run_op(8, 32'hFF, 32'h01, 32'hFE, 1'b0, "FF-01");
        run_op(8, 32'h00, 32'hFF, 32'h01, 1'b1, "00-FF");

        // Start pulse during SHIFT must be ignored; previous diff (01) held.
        s8 = 1; a8 = 8'h10; b8 = 8'h01; dcnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) begin
                chk("ign/held_diff", diff8, 8'h01);
                chk("ign/held_borrow", bo8, 1'b1);
            end
            if (done8) begin
                dcnt++;
                chk("ign/done_cycle", i, 9);
                chk("ign/diff", diff8, 8'h0F);
                chk("ign/borrow", bo8, 1'b0);
            end
            s8 = (i == 3);
            if (i == 3) begin a8 = 8'hAA; b8 = 8'h55; end
        end
        chk("ign/done_count", dcnt, 1);

        // Back-to-back with start held high.
        s8 = 1; a8 = 8'h80; b8 = 8'h01; dcnt = 0; low = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (!busy8) low++;
            if (done8) dcnt++;
            if (i == 9) begin
                chk("b2b/done1", done8, 1'b1);
                chk("b2b/diff1", diff8, 8'h7F);
                chk("b2b/borrow1", bo8, 1'b0);
                a8 = 8'h01; b8 = 8'h02;
            end
            if (i == 18) begin
                chk("b2b/done2", done8, 1'b1);
                chk("b2b/diff2", diff8, 8'hFF);
                chk("b2b/borrow2", bo8, 1'b1);
                s8 = 0;
            end
        end
        chk("b2b/idle_cycles", low, 2);
        chk("b2b/done_count", dcnt, 2);
        @(negedge clk);

        // Reset in SHIFT cycle 4 discards the op and clears the held result.
        s8 = 1; a8 = 8'h05; b8 = 8'h03; dcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            s8 = 0;
            if (i == 4) rst = 1'b1;
            if (i == 5) begin
                rst = 1'b0;
                chk("rst/busy", busy8, 1'b0);
                chk("rst/done", done8, 1'b0);
                chk("rst/diff", diff8, 8'h00);
                chk("rst/borrow", bo8, 1'b0);
            end
            if (i > 5 && done8) dcnt++;
        end
        chk("rst/no_done", dcnt, 0);
        run_op(8, 32'h05, 32'h03, 32'h02, 1'b0, "fresh");

        run_op(1, 32'h0, 32'h0, 32'h0, 1'b0, "w1_00");
        run_op(1, 32'h0, 32'h1, 32'h1, 1'b1, "w1_01");
        run_op(1, 32'h1, 32'h0, 32'h1, 1'b0, "w1_10");
        run_op(1, 32'h1, 32'h1, 32'h0, 1'b0, "w1_11");

        m = 32'hFF;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & m; rb = $urandom & m;
            run_op(8, ra, rb, (ra - rb) & m, ra < rb, "rnd8");
        end
        m = 32'h1FFF;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom & m; rb = $urandom & m;
            run_op(13, ra, rb, (ra - rb) & m, ra < rb, "rnd13");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
